draw_field_pipe: RTL and testbench
==================================

// Module: draw_field_pipe
// PURPOSE
// Parametrised, pipelined successor of the tetris playfield renderer. Maps pixel coords to main-field and
// next-block-preview (NBP) cells, looks up cell colour, adds a frame-timed line-clear flash animation.
// Sits between the VGA timing generator and the pixel mux. Output is registered, fixed latency 2.
// PARAMETERS
// PIX_WIDTH      12   pixel coordinate width
// COLS           10   main field columns
// ROWS           20   main field rows
// CW             3    colour index width (palette size 2**CW, max 8)
// BRICK          30   brick edge, pixels
// BORDER         2    border between/around bricks, pixels; cell pitch P = BRICK+BORDER
// MAIN_X/MAIN_Y  300/200  main field top-left pixel
// NBP_X/NBP_Y    670/200  preview top-left pixel
// NBP_CNT        6    preview cells per side (outer ring always empty)
// FLASH_FRAMES   8    frames per flash half-period
// FLASH_CYCLES   3    on/off pairs per animation
// PORTS
// clk                    in  1            clock
// rst_i                  in  1            synchronous reset, active-high
// frame_start_i          in  1            one-cycle pulse per video frame
// pix_x_i, pix_y_i       in  PIX_WIDTH    current pixel
// gd_field               in  ROWS*COLS*CW cell(r,c) at [CW*(COLS*r+c) +: CW], row 0 top
// gd_next_block_data     in  64           4 rotations x 16 bits, rotation k at [16*k +: 16]
// gd_next_block_color    in  CW           preview colour index
// gd_next_block_rotation in  2            preview rotation
// gd_next_block_draw_en  in  1            preview enable
// gd_game_over_i         in  1            game-over state (used only with macro)
// flash_rows_i           in  ROWS         rows to flash, bit r = row r
// flash_start_i          in  1            start animation (pulse)
// flash_busy_o           out 1            animation running
// flash_done_o           out 1            one-cycle pulse at animation end
// vga_data_o             out 24           RGB888
// vga_data_en_o          out 1            pixel inside main field or preview
// BEHAVIOUR
// - Reset: all pipeline regs, vga_data_o, vga_data_en_o, flash_busy_o, flash_done_o = 0; FSM IDLE.
// - Geometry: field spans [X0, X0+N*P+BORDER) per axis. dx=x-X0; in_brick when (dx mod P)>=BORDER and
//   dx<N*P+BORDER-? no: dx<N*P, likewise y; col=dx/P, row=dy/P (constant division). Last BORDER px = border.
// - Stage 1 (cycle N+1): register in_field/in_brick/col/row for main and NBP, flash hit.
//   Stage 2 (N+2): register vga_data_o/vga_data_en_o. Inputs sampled at N; gd_* changes take effect likewise.
// - Priority: main field over NBP. In field, not brick -> COLOR_BORDERS. Brick -> palette COLOR_BRICKS_k.
//   vga_data_en_o=0 -> vga_data_o=24'h0.
// - NBP cell(i,j): ring (i or j = 0 or NBP_CNT-1) -> index 0; else
//   data[16*rot+4*(i-1)+(j-1)] && draw_en ? gd_next_block_color : 0.
// - Flash FSM IDLE -> ON -> OFF -> ON ... -> DONE -> IDLE.
//   IDLE: flash_start_i latches flash_rows_i, frame cnt=0, pair cnt=0 -> ON; busy=1 from next cycle.
//   ON/OFF: each frame_start_i increments frame cnt; at FLASH_FRAMES-th frame toggle state, cnt=0.
//   OFF->ON increments pair cnt; after FLASH_CYCLES pairs, OFF exits to DONE instead.
//   DONE: flash_done_o=1 one cycle, busy=0 -> IDLE. Total = 2*FLASH_FRAMES*FLASH_CYCLES frames.
// - During ON, main-field bricks in latched rows render COLOR_FLASH (borders unchanged); OFF = normal.
// - flash_start_i while busy or in DONE: ignored. frame_start_i coinciding with start: not counted.
// - flash_rows_i==0 at start: animation still runs full length, no visible change.
// - rst_i mid-animation: immediate IDLE, latched rows cleared, no done pulse.
// CONFIGURATION
// - DRAW_FIELD_GAME_OVER_DIM_EN defined: when gd_game_over_i=1, each 8-bit channel of every brick
//   colour (main and NBP, not borders) shifted right 1 at stage 2. Undefined: gd_game_over_i ignored.
// TESTING
// - rst_i=1 2 cycles, pixel (302,202) -> vga_data_o=0, en=0, busy=0, done=0 during and 1 cycle after.
// - Cell(0,0)=3, pixel (302,202) at cycle N -> N+2 data=COLOR_BRICKS_3, en=1; (300,200) -> COLOR_BORDERS.
// - Pixel (299,200) and (622,200) -> en=0, data=0; (621,200) -> COLOR_BORDERS, en=1.
// - NBP rot=1, data[16+0]=1, color=5, draw_en=1: pixel (704,234) -> COLOR_BRICKS_5; draw_en=0 -> BRICKS_0.
// - flash_rows_i=bit19, start, 48 frame_start pulses -> row 19 flash for frames 1-8,17-24,33-40;
//   done pulse after 48th; second start at frame 10 ignored.
// - Macro on, game_over=1, brick colour 24'hFF8040 -> 24'h7F4020; borders unchanged.

Source files
------------

// File: rtl/draw_field_pipe.sv
// Pipelined playfield renderer: main field + next-block preview with a line-clear flash animation.
// Optional build macro DRAW_FIELD_GAME_OVER_DIM_EN halves brick colours while gd_game_over_i is set.
module draw_field_pipe #(
  parameter int PIX_WIDTH    = 12,
  parameter int COLS         = 10,
  parameter int ROWS         = 20,
  parameter int CW           = 3,
  parameter int BRICK        = 30,
  parameter int BORDER       = 2,
  parameter int MAIN_X       = 300,
  parameter int MAIN_Y       = 200,
  parameter int NBP_X        = 670,
  parameter int NBP_Y        = 200,
  parameter int NBP_CNT      = 6,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_CYCLES = 3,
  parameter logic [23:0] COLOR_BORDERS = 24'h404040,
  parameter logic [23:0] COLOR_FLASH   = 24'hFFFFFF,
  parameter logic [7:0][23:0] COLOR_BRICKS = {24'hFF00FF, 24'h00FFFF, 24'hFFFF00, 24'h0000FF,
                                              24'hFF8040, 24'h00FF00, 24'hFF0000, 24'h101010}
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    frame_start_i,
  input  logic [PIX_WIDTH-1:0]    pix_x_i,
  input  logic [PIX_WIDTH-1:0]    pix_y_i,
  input  logic [ROWS*COLS*CW-1:0] gd_field,
  input  logic [63:0]             gd_next_block_data,
  input  logic [CW-1:0]           gd_next_block_color,
  input  logic [1:0]              gd_next_block_rotation,
  input  logic                    gd_next_block_draw_en,
  input  logic                    gd_game_over_i,
  input  logic [ROWS-1:0]         flash_rows_i,
  input  logic                    flash_start_i,
  output logic                    flash_busy_o,
  output logic                    flash_done_o,
  output logic [23:0]             vga_data_o,
  output logic                    vga_data_en_o
);

  localparam int P   = BRICK + BORDER;
  localparam int CB  = $clog2(COLS);
  localparam int RB  = $clog2(ROWS);
  localparam int NB  = $clog2(NBP_CNT);
  localparam int FIW = $clog2(ROWS*COLS*CW);
  localparam int FCW = $clog2(FLASH_FRAMES + 1);
  localparam int PCW = $clog2(FLASH_CYCLES + 1);
  localparam logic [PIX_WIDTH-1:0] PP = PIX_WIDTH'(P);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_DONE} flash_state_t;

  flash_state_t           state_q, state_d;
  logic [FCW-1:0]         frame_q, frame_d;
  logic [PCW-1:0]         pair_q, pair_d;
  logic [ROWS-1:0]        rows_q, rows_d;

  // ---------------- flash animation FSM ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst_i) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      pair_q  <= '0;
      rows_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      pair_q  <= pair_d;
      rows_q  <= rows_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    frame_d = frame_q;
    pair_d  = pair_q;
    rows_d  = rows_q;
    unique case (state_q)
      ST_IDLE: if (flash_start_i) begin
        rows_d  = flash_rows_i;
        frame_d = '0;
        pair_d  = '0;
        state_d = ST_ON;
      end
      ST_ON: if (frame_start_i) begin
        if (frame_q == FCW'(FLASH_FRAMES - 1)) begin
          frame_d = '0;
          state_d = ST_OFF;
        end else frame_d = frame_q + 1'b1;
      end
      ST_OFF: if (frame_start_i) begin
        if (frame_q == FCW'(FLASH_FRAMES - 1)) begin
          frame_d = '0;
          if (pair_q == PCW'(FLASH_CYCLES - 1)) state_d = ST_DONE;
          else begin
            pair_d  = pair_q + 1'b1;
            state_d = ST_ON;
          end
        end else frame_d = frame_q + 1'b1;
      end
      ST_DONE: begin
        rows_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flash_busy_o = (state_q == ST_ON) || (state_q == ST_OFF);
  assign flash_done_o = (state_q == ST_DONE);

  // ---------------- geometry and cell lookup ----------------
  logic [PIX_WIDTH-1:0] mdx, mdy, ndx, ndy;
  logic                 main_in, main_brick, nbp_in, nbp_brick, nbp_ring;
  logic [CB-1:0]        main_col;
  logic [RB-1:0]        main_row;
  logic [NB-1:0]        nbp_i, nbp_j;
  logic [FIW-1:0]       fbase;
  logic [5:0]           nbit;
  logic [CW-1:0]        main_idx, nbp_idx;

  always_comb begin
    mdx = pix_x_i - PIX_WIDTH'(MAIN_X);
    mdy = pix_y_i - PIX_WIDTH'(MAIN_Y);
    ndx = pix_x_i - PIX_WIDTH'(NBP_X);
    ndy = pix_y_i - PIX_WIDTH'(NBP_Y);

    main_in = (pix_x_i >= PIX_WIDTH'(MAIN_X)) && (mdx < PIX_WIDTH'(COLS*P + BORDER)) &&
              (pix_y_i >= PIX_WIDTH'(MAIN_Y)) && (mdy < PIX_WIDTH'(ROWS*P + BORDER));
    main_brick = main_in && (mdx < PIX_WIDTH'(COLS*P)) && (mdy < PIX_WIDTH'(ROWS*P)) &&
                 (mdx % PP >= PIX_WIDTH'(BORDER)) && (mdy % PP >= PIX_WIDTH'(BORDER));
    main_col = CB'(mdx / PP);
    main_row = RB'(mdy / PP);
    fbase    = FIW'(CW * (COLS * int'(main_row) + int'(main_col)));
    main_idx = '0;
    if (main_brick) main_idx = gd_field[fbase +: CW];

    nbp_in = (pix_x_i >= PIX_WIDTH'(NBP_X)) && (ndx < PIX_WIDTH'(NBP_CNT*P + BORDER)) &&
             (pix_y_i >= PIX_WIDTH'(NBP_Y)) && (ndy < PIX_WIDTH'(NBP_CNT*P + BORDER));
    nbp_brick = nbp_in && (ndx < PIX_WIDTH'(NBP_CNT*P)) && (ndy < PIX_WIDTH'(NBP_CNT*P)) &&
                (ndx % PP >= PIX_WIDTH'(BORDER)) && (ndy % PP >= PIX_WIDTH'(BORDER));
    nbp_j    = NB'(ndx / PP);
    nbp_i    = NB'(ndy / PP);
    nbp_ring = (nbp_i == '0) || (nbp_j == '0) ||
               (nbp_i == NB'(NBP_CNT - 1)) || (nbp_j == NB'(NBP_CNT - 1));
    nbit     = 6'(16 * int'(gd_next_block_rotation) + 4 * (int'(nbp_i) - 1) + (int'(nbp_j) - 1));
    nbp_idx  = '0;
    if (nbp_brick && !nbp_ring && gd_next_block_draw_en && gd_next_block_data[nbit])
      nbp_idx = gd_next_block_color;
  end

  // ---------------- stage 1: resolved cell, main field wins ----------------
  logic          s1_in, s1_brick, s1_flash, s1_dim;
  logic [CW-1:0] s1_idx;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      s1_in    <= 1'b0;
      s1_brick <= 1'b0;
      s1_flash <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_in    <= main_in || nbp_in;
      s1_brick <= main_in ? main_brick : nbp_brick;
      s1_idx   <= main_in ? main_idx : nbp_idx;
      s1_flash <= main_brick && (state_q == ST_ON) && rows_q[main_row];
    end
  end

`ifdef DRAW_FIELD_GAME_OVER_DIM_EN
  always_ff @(posedge clk) begin
    if (rst_i) s1_dim <= 1'b0;
    else       s1_dim <= gd_game_over_i;
  end
`else
  logic unused_game_over;
  assign unused_game_over = gd_game_over_i;
  assign s1_dim = 1'b0;
`endif

  // ---------------- stage 2: palette and output register ----------------
  logic [23:0] brick_rgb, pix_rgb;

  always_comb begin
    brick_rgb = s1_flash ? COLOR_FLASH : COLOR_BRICKS[3'(s1_idx)];
    if (s1_dim) brick_rgb = {1'b0, brick_rgb[23:17], 1'b0, brick_rgb[15:9], 1'b0, brick_rgb[7:1]};
    pix_rgb = s1_brick ? brick_rgb : COLOR_BORDERS;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      vga_data_o    <= '0;
      vga_data_en_o <= 1'b0;
    end else begin
      vga_data_o    <= s1_in ? pix_rgb : 24'h0;
      vga_data_en_o <= s1_in;
    end
  end

endmodule

// File: tb/tb_draw_field_pipe.sv
// Self-checking bench for draw_field_pipe: frame-level reference model compared every cycle,
// plus directed pixels with hand-computed colours.
module tb_draw_field_pipe;

  localparam logic [23:0] BORDERS = 24'h404040;
  localparam logic [23:0] FLASH   = 24'hFFFFFF;
  localparam logic [23:0] PAL [8] = '{24'h101010, 24'hFF0000, 24'h00FF00, 24'hFF8040,
                                      24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF};

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         frame_start_i = 1'b0;
  logic [11:0]  pix_x_i = 12'd302;
  logic [11:0]  pix_y_i = 12'd202;
  logic [599:0] gd_field = '0;
  logic [63:0]  gd_next_block_data = '0;
  logic [2:0]   gd_next_block_color = '0;
  logic [1:0]   gd_next_block_rotation = '0;
  logic         gd_next_block_draw_en = 1'b0;
  logic         gd_game_over_i = 1'b0;
  logic [19:0]  flash_rows_i = '0;
  logic         flash_start_i = 1'b0;
  logic         flash_busy_o, flash_done_o, vga_data_en_o;
  logic [23:0]  vga_data_o;

  int checks = 0;
  int failures = 0;
  int cells [20][10];

  draw_field_pipe dut (
    .clk(clk), .rst_i(rst_i), .frame_start_i(frame_start_i),
    .pix_x_i(pix_x_i), .pix_y_i(pix_y_i), .gd_field(gd_field),
    .gd_next_block_data(gd_next_block_data), .gd_next_block_color(gd_next_block_color),
    .gd_next_block_rotation(gd_next_block_rotation), .gd_next_block_draw_en(gd_next_block_draw_en),
    .gd_game_over_i(gd_game_over_i), .flash_rows_i(flash_rows_i), .flash_start_i(flash_start_i),
    .flash_busy_o(flash_busy_o), .flash_done_o(flash_done_o),
    .vga_data_o(vga_data_o), .vga_data_en_o(vga_data_en_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_cell(input int r, input int c, input int v);
    logic [9:0] b;
    b = 10'(3 * (10 * r + c));
    cells[r][c] = v;
    gd_field[b +: 3] = 3'(v);
  endtask

  // ---------------- reference model ----------------
  logic        m_active = 1'b0, m_done = 1'b0;
  int          m_frames = 0;
  logic [19:0] m_rows = '0;

  function automatic logic [24:0] model_pix(input logic fl_on);
    int x, y, dx, dy, r, c, b, idx;
    logic [23:0] rgb;
    logic en, brick;
    x = int'(pix_x_i);
    y = int'(pix_y_i);
    rgb = 24'h0; en = 1'b0; brick = 1'b0;
    if (x >= 300 && x < 622 && y >= 200 && y < 842) begin
      dx = x - 300; dy = y - 200; en = 1'b1; rgb = BORDERS;
      if (dx < 320 && dy < 640 && dx % 32 >= 2 && dy % 32 >= 2) begin
        r = dy / 32; c = dx / 32; brick = 1'b1;
        rgb = (fl_on && m_rows[r[4:0]]) ? FLASH : PAL[cells[r][c][2:0]];
      end
    end else if (x >= 670 && x < 864 && y >= 200 && y < 394) begin
      dx = x - 670; dy = y - 200; en = 1'b1; rgb = BORDERS;
      if (dx < 192 && dy < 192 && dx % 32 >= 2 && dy % 32 >= 2) begin
        r = dy / 32; c = dx / 32; brick = 1'b1; idx = 0;
        if (r != 0 && c != 0 && r != 5 && c != 5) begin
          b = 16 * int'(gd_next_block_rotation) + 4 * (r - 1) + (c - 1);
          if (gd_next_block_draw_en && gd_next_block_data[b[5:0]]) idx = int'(gd_next_block_color);
        end
        rgb = PAL[idx[2:0]];
      end
    end
`ifdef DRAW_FIELD_GAME_OVER_DIM_EN
    if (brick && gd_game_over_i)
      rgb = {rgb[23:16] >> 1, rgb[15:8] >> 1, rgb[7:0] >> 1};
`endif
    return {en, rgb};
  endfunction

  logic [24:0] e_now, e_q = '0;
  logic        r_now, on_now;

  // Compare process: outputs after edge k reflect inputs sampled at edge k-1.
  always @(posedge clk) begin
    r_now  = rst_i;
    on_now = m_active && ((m_frames / 8) % 2 == 0);
    e_now  = r_now ? 25'd0 : model_pix(on_now);
    if (r_now) begin
      m_active = 1'b0; m_done = 1'b0; m_frames = 0; m_rows = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (flash_start_i) begin
        m_active = 1'b1; m_frames = 0; m_rows = flash_rows_i;
      end
    end else if (frame_start_i) begin
      m_frames++;
      if (m_frames == 48) begin
        m_active = 1'b0; m_done = 1'b1;
      end
    end
    #1;
    if (r_now) begin
      check("model rgb", 32'(vga_data_o), 32'h0);
      check("model en", 32'(vga_data_en_o), 32'h0);
    end else begin
      check("model rgb", 32'(vga_data_o), 32'(e_q[23:0]));
      check("model en", 32'(vga_data_en_o), 32'(e_q[24]));
    end
    check("model busy", 32'(flash_busy_o), 32'(m_active));
    check("model done", 32'(flash_done_o), 32'(m_done));
    e_q = e_now;
  end

  task automatic probe(input int x, input int y, input logic [23:0] rgb, input logic en,
                       input string name);
    @(negedge clk);
    pix_x_i = 12'(x);
    pix_y_i = 12'(y);
    @(posedge clk);
    @(posedge clk);
    #2;
    check({name, " rgb"}, 32'(vga_data_o), 32'(rgb));
    check({name, " en"}, 32'(vga_data_en_o), 32'(en));
  endtask

  task automatic pulse_frame();
    @(negedge clk) frame_start_i = 1'b1;
    @(negedge clk) frame_start_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) cells[r][c] = 0;
    set_cell(0, 0, 3);

    // Reset held for two edges, outputs stay zero through one edge after release.
    @(posedge clk); #2;
    check("rst1 rgb", 32'(vga_data_o), 32'h0);
    check("rst1 en", 32'(vga_data_en_o), 32'h0);
    @(posedge clk); #2;
    check("rst2 busy", 32'(flash_busy_o), 32'h0);
    @(negedge clk) rst_i = 1'b0;
    @(posedge clk); #2;
    check("post rst rgb", 32'(vga_data_o), 32'h0);
    check("post rst en", 32'(vga_data_en_o), 32'h0);
    check("post rst done", 32'(flash_done_o), 32'h0);

    probe(302, 202, 24'hFF8040, 1'b1, "cell00 brick");
    probe(300, 200, BORDERS, 1'b1, "field corner");
    probe(299, 200, 24'h0, 1'b0, "left of field");
    probe(622, 200, 24'h0, 1'b0, "right of field");
    probe(621, 200, BORDERS, 1'b1, "last border col");
    probe(302, 841, BORDERS, 1'b1, "last border row");
    @(negedge clk) set_cell(5, 7, 6);
    probe(526, 362, 24'h00FFFF, 1'b1, "cell57 brick");

    @(negedge clk);
    gd_next_block_rotation = 2'd1;
    gd_next_block_data     = 64'h0000_0000_0001_0000;
    gd_next_block_color    = 3'd5;
    gd_next_block_draw_en  = 1'b1;
    probe(704, 234, 24'hFFFF00, 1'b1, "nbp on");
    probe(672, 202, 24'h101010, 1'b1, "nbp ring");
    probe(670, 200, BORDERS, 1'b1, "nbp border");
    @(negedge clk) gd_next_block_draw_en = 1'b0;
    probe(704, 234, 24'h101010, 1'b1, "nbp disabled");

`ifdef DRAW_FIELD_GAME_OVER_DIM_EN
    @(negedge clk) gd_game_over_i = 1'b1;
    probe(302, 202, 24'h7F4020, 1'b1, "dim brick");
    probe(300, 200, BORDERS, 1'b1, "dim border");
    @(negedge clk) gd_game_over_i = 1'b0;
`endif

    // Flash row 19 for three on/off pairs; a second start mid-run must be ignored.
    @(negedge clk) set_cell(19, 0, 2);
    probe(302, 810, 24'h00FF00, 1'b1, "row19 normal");
    @(negedge clk); flash_rows_i = 20'h80000; flash_start_i = 1'b1;
    @(negedge clk); flash_rows_i = 20'h0; flash_start_i = 1'b0;
    check("flash busy", 32'(flash_busy_o), 32'h1);
    repeat (3) @(negedge clk);
    check("flash frame0", 32'(vga_data_o), 32'(FLASH));
    for (int f = 1; f <= 48; f++) begin
      @(negedge clk) frame_start_i = 1'b1;
      @(posedge clk); #2;
      if (f == 48) begin
        check("done pulse", 32'(flash_done_o), 32'h1);
        check("done busy", 32'(flash_busy_o), 32'h0);
      end
      @(negedge clk) frame_start_i = 1'b0;
      repeat (3) @(negedge clk);
      if (f == 4 || f == 20 || f == 36) check("flash on", 32'(vga_data_o), 32'(FLASH));
      if (f == 12 || f == 28 || f == 44) check("flash off", 32'(vga_data_o), 32'h00FF00);
      if (f == 10) begin
        @(negedge clk); flash_rows_i = 20'h1; flash_start_i = 1'b1;
        @(negedge clk); flash_rows_i = 20'h0; flash_start_i = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
    check("after done rgb", 32'(vga_data_o), 32'h00FF00);
    check("after done busy", 32'(flash_busy_o), 32'h0);

    // Reset in the middle of an animation: straight back to idle, no done pulse.
    @(negedge clk); flash_rows_i = 20'h80000; flash_start_i = 1'b1;
    @(negedge clk); flash_rows_i = 20'h0; flash_start_i = 1'b0;
    pulse_frame();
    pulse_frame();
    @(negedge clk) rst_i = 1'b1;
    @(negedge clk) rst_i = 1'b0;
    check("mid rst busy", 32'(flash_busy_o), 32'h0);
    repeat (6) pulse_frame();

    // Empty row mask: full-length animation, nothing visibly changes.
    @(negedge clk); flash_rows_i = 20'h0; flash_start_i = 1'b1;
    @(negedge clk) flash_start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("empty mask rgb", 32'(vga_data_o), 32'h00FF00);
    check("empty mask busy", 32'(flash_busy_o), 32'h1);
    repeat (4) pulse_frame();

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
